feature_match_decide: RTL and testbench
=======================================

FEATURE_MATCH_DECIDE -- requirements
Module: feature_match_decide

Interface
REQ-001 Parameter MODN, default 30, number of stored feature models, one 4-bit diff lane each.
REQ-002 Parameter ACCW, default 12, per-model accumulator width in bits.
REQ-003 Localparam IDXW = ceil(log2(MODN)), width of the model index.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 frame_start  input  1  single-cycle pulse; begin a new match frame.
REQ-007 diff_vld  input  1  diff_bus holds a valid per-model diff sample this cycle.
REQ-008 diff_bus  input  MODN*4  lane i = bits [i*4 +: 4] = unsigned diff of model i.
REQ-009 frame_end  input  1  single-cycle pulse; last sample of the frame.
REQ-010 match_rdy  input  1  downstream accepts the result.
REQ-011 match_vld  output  1  result valid.
REQ-012 match_idx  output  IDXW  index of best (lowest-score) model.
REQ-013 match_score  output  ACCW  accumulated score of the best model.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, ACCUM, SCAN, OUT; registered, one transition per edge.
REQ-016 IDLE: frame_start -> ACCUM, all MODN accumulators cleared to 0 on the same edge.
REQ-017 ACCUM: on each diff_vld edge, acc[i] <= acc[i] + lane i, saturating at 2^ACCW-1, for all i in parallel.
REQ-018 ACCUM: frame_end -> SCAN; a diff_vld sample coincident with frame_end is accumulated.
REQ-019 ACCUM: frame_start clears all accumulators and stays in ACCUM (frame restart); when frame_start and frame_end coincide, frame_start wins.
REQ-020 SCAN: examine acc[k] for k = 0..MODN-1, one per cycle; MODN cycles total; k resets to 0 on SCAN entry.
REQ-021 Running minimum: k=0 loads unconditionally; thereafter update only when acc[k] < current min (strict), so ties resolve to lowest index.
REQ-022 After k = MODN-1, next edge -> OUT; match_vld rises exactly MODN+1 edges after the edge sampling frame_end.
REQ-023 OUT: match_vld, match_idx, match_score held stable until match_rdy sampled high; that edge -> IDLE, match_vld deasserts.
REQ-024 frame_start, frame_end, diff_vld ignored in SCAN and OUT; frame_end and diff_vld ignored in IDLE.
REQ-025 match_idx/match_score registered; they update only on entry to OUT and hold their values in other states.

Reset
REQ-026 rst_n low: state IDLE, all accumulators 0, scan index 0, match_vld 0, match_idx 0, match_score 0, busy 0.
REQ-027 Reset asserted in any state, including mid-SCAN or OUT, discards the frame; no result is emitted after release.

Configuration
REQ-028 Macro FEATURE_MATCH_THRESH_EN: when defined, adds input match_thresh (ACCW bits) and output no_match (1 bit, reset 0).
REQ-029 With the macro, on entry to OUT, if min score > match_thresh then no_match = 1 and match_idx = all ones; otherwise no_match = 0 and match_idx = the REQ-021 winner. match_score always = the min.
REQ-030 Without the macro, the ports do not exist and the REQ-021 winner is always reported.

Verification (MODN=30, ACCW=12)
REQ-031 frame_start, 4 diff_vld samples with lane 7 = 1 and all other lanes = 5, frame_end -> match_vld at frame_end edge + 31, idx=7, score=4.
REQ-032 Lanes 3 and 12 = 0, others = 9, 10 samples -> idx=3, score=0 (tie keeps lowest index).
REQ-033 All lanes = 15 for 300 samples -> every acc saturates at 4095, idx=0, score=4095.
REQ-034 match_rdy held low 20 cycles in OUT -> outputs stable throughout; rdy high -> IDLE next edge, match_vld=0, busy=0.
REQ-035 Accumulate 3 samples, then frame_start, then 2 samples of lane 5 = 0, others = 2 -> idx=5, score=0; pre-restart samples excluded.
REQ-036 rst_n pulsed low at SCAN k=10 -> all outputs 0 immediately; no match_vld follows. With FEATURE_MATCH_THRESH_EN, match_thresh=3 and min score 4 -> no_match=1, idx=31.

Source files
------------

// File: rtl/feature_match_decide.sv
// feature_match_decide
//   Accumulates per-model 4-bit diff samples over a frame and then picks the
//   model with the lowest accumulated score.
//
//   Flow: IDLE --frame_start--> ACCUM --frame_end--> SCAN (MODN+1 cycles)
//         --> OUT --match_rdy--> IDLE
//
// Handshake (match_vld/match_rdy): a result transfers on the rising edge where
//   both match_vld and match_rdy are high. match_vld never depends on
//   match_rdy, and once high it stays high with match_idx/match_score stable
//   until that transfer edge.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   frame_start       pulse: start (or restart) a frame, clears accumulators
//   diff_vld/diff_bus per-model diff sample, lane i = diff_bus[i*4 +: 4]
//   frame_end         pulse: last sample of the frame (sample still counted)
//   match_rdy         downstream accepts the result
//   match_vld         result valid (OUT state)
//   match_idx         index of the lowest-score model (lowest index on ties)
//   match_score       accumulated score of that model
//   busy              high in every state except IDLE
//   state_dbg         current FSM state (0 IDLE, 1 ACCUM, 2 SCAN, 3 OUT)
//
// Optional feature, macro FEATURE_MATCH_THRESH_EN:
//   match_thresh      input, scores above it are rejected
//   no_match          output, set when the best score exceeds match_thresh;
//                     match_idx is then forced to all ones
module feature_match_decide #(
    parameter int MODN = 30,
    parameter int ACCW = 12,
    localparam int IDXW = (MODN > 1) ? $clog2(MODN) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              diff_vld,
    input  logic [MODN*4-1:0] diff_bus,
    input  logic              frame_end,
    input  logic              match_rdy,
    output logic              match_vld,
    output logic [IDXW-1:0]   match_idx,
    output logic [ACCW-1:0]   match_score,
    output logic              busy,
    output logic [1:0]        state_dbg
`ifdef FEATURE_MATCH_THRESH_EN
    ,
    input  logic [ACCW-1:0]   match_thresh,
    output logic              no_match
`endif
);

    // The scan index runs 0..MODN: values below MODN examine one accumulator,
    // the final value MODN is the decision cycle that loads the outputs.
    localparam int KW = $clog2(MODN + 1);
    localparam logic [KW-1:0] K_LAST = KW'(MODN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCAN  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ACCW-1:0] acc [MODN];
    logic [KW-1:0]   k;
    logic [IDXW-1:0] k_idx;
    logic [ACCW-1:0] cur_acc;
    logic [ACCW-1:0] min_score;
    logic [IDXW-1:0] min_idx;

    function automatic logic [ACCW-1:0] sat_add(input logic [ACCW-1:0] a,
                                                input logic [3:0]      d);
        logic [ACCW:0] sum;
        sum = {1'b0, a} + {{(ACCW-3){1'b0}}, d};
        if (sum[ACCW]) begin
            return '1;
        end
        return sum[ACCW-1:0];
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                // A restart takes priority over a coincident frame_end.
                if (frame_start) begin
                    state_d = ACCUM;
                end else if (frame_end) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (k == K_LAST) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (match_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign match_vld = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

    // ---------------- Accumulators ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MODN; i++) begin
                acc[i] <= '0;
            end
        end else if (((state_q == IDLE) || (state_q == ACCUM)) && frame_start) begin
            for (int i = 0; i < MODN; i++) begin
                acc[i] <= '0;
            end
        end else if ((state_q == ACCUM) && diff_vld) begin
            for (int i = 0; i < MODN; i++) begin
                acc[i] <= sat_add(acc[i], diff_bus[i*4 +: 4]);
            end
        end
    end

    // ---------------- Scan / running minimum ----------------
    assign k_idx = k[IDXW-1:0];

    always_comb begin
        cur_acc = '0;
        if (k < K_LAST) begin
            cur_acc = acc[k_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k         <= '0;
            min_score <= '0;
            min_idx   <= '0;
        end else if (state_q == SCAN) begin
            if (k < K_LAST) begin
                // Strict less-than keeps the lowest index on ties.
                if ((k == '0) || (cur_acc < min_score)) begin
                    min_score <= cur_acc;
                    min_idx   <= k_idx;
                end
                k <= k + KW'(1);
            end else begin
                k <= '0;
            end
        end else begin
            k <= '0;
        end
    end

    // ---------------- Result registers (load on entry to OUT) ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_idx   <= '0;
            match_score <= '0;
`ifdef FEATURE_MATCH_THRESH_EN
            no_match    <= 1'b0;
`endif
        end else if ((state_q == SCAN) && (k == K_LAST)) begin
            match_score <= min_score;
`ifdef FEATURE_MATCH_THRESH_EN
            if (min_score > match_thresh) begin
                no_match  <= 1'b1;
                match_idx <= '1;
            end else begin
                no_match  <= 1'b0;
                match_idx <= min_idx;
            end
`else
            match_idx   <= min_idx;
`endif
        end
    end

endmodule

// File: tb/tb_feature_match_decide.sv
module tb_feature_match_decide;

  localparam int MODN = 30;
  localparam int ACCW = 12;
  localparam int IDXW = 5;
  localparam int NVEC = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              frame_start = 1'b0;
  logic              diff_vld = 1'b0;
  logic [MODN*4-1:0] diff_bus = '0;
  logic              frame_end = 1'b0;
  logic              match_rdy = 1'b0;
  logic              match_vld;
  logic [IDXW-1:0]   match_idx;
  logic [ACCW-1:0]   match_score;
  logic              busy;
  logic [1:0]        state_dbg;
`ifdef FEATURE_MATCH_THRESH_EN
  logic [ACCW-1:0]   match_thresh = '1;
  logic              no_match;
  logic              exp_nm = 1'b0;
`endif

  feature_match_decide #(.MODN(MODN), .ACCW(ACCW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .diff_vld    (diff_vld),
    .diff_bus    (diff_bus),
    .frame_end   (frame_end),
    .match_rdy   (match_rdy),
    .match_vld   (match_vld),
    .match_idx   (match_idx),
    .match_score (match_score),
    .busy        (busy),
    .state_dbg   (state_dbg)
`ifdef FEATURE_MATCH_THRESH_EN
    ,
    .match_thresh(match_thresh),
    .no_match    (no_match)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [IDXW+ACCW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MODN*4-1:0] make_bus(input logic [3:0] base, input int sa,
                                                 input logic [3:0] sav, input int sb,
                                                 input logic [3:0] sbv);
    logic [MODN*4-1:0] b;
    logic [3:0] lane;
    b = '0;
    for (int i = 0; i < MODN; i++) begin
      lane = base;
      if (i == sa) lane = sav;
      if (i == sb) lane = sbv;
      b[i*4 +: 4] = lane;
    end
    return b;
  endfunction

  task automatic send_samples(input logic [MODN*4-1:0] bus, input int n, input logic last_end);
    for (int s = 0; s < n; s++) begin
      diff_vld = 1'b1;
      diff_bus = bus;
      frame_end = last_end && (s == n - 1);
      tick();
    end
    diff_vld = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic send_frame(input logic [MODN*4-1:0] bus, input int n);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    send_samples(bus, n, 1'b1);
  endtask

  // Called just after the frame_end edge; counts edges until match_vld.
  // Pokes frame_start/frame_end/diff_vld mid-scan, which must be ignored.
  task automatic wait_result(input string name);
    int lat;
    lat = 0;
    while (!match_vld && lat < 100) begin
      frame_start = (lat == 3);
      frame_end = (lat == 3);
      diff_vld = (lat == 3);
      if (lat == 3) diff_bus = '1;
      tick();
      lat++;
    end
    frame_start = 1'b0;
    frame_end = 1'b0;
    diff_vld = 1'b0;
    check({name, "_latency"}, lat, MODN + 1);
  endtask

  task automatic finish_result(input string name, input int hold);
    logic [IDXW+ACCW-1:0] e;
    logic ok;
    if (exp_q.size() == 0) begin
      check({name, "_exp_queue"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check({name, "_vld"}, match_vld, 1);
    check({name, "_idx"}, match_idx, e[IDXW+ACCW-1:ACCW]);
    check({name, "_score"}, match_score, e[ACCW-1:0]);
`ifdef FEATURE_MATCH_THRESH_EN
    check({name, "_no_match"}, no_match, exp_nm);
`endif
    for (int i = 0; i < hold; i++) begin
      frame_start = (i == 0);
      tick();
      ok = match_vld && busy && (match_idx == e[IDXW+ACCW-1:ACCW]) && (match_score == e[ACCW-1:0]);
      check({name, "_hold_stable"}, ok, 1);
    end
    frame_start = 1'b0;
    match_rdy = 1'b1;
    tick();
    match_rdy = 1'b0;
    check({name, "_vld_after_rdy"}, match_vld, 0);
    check({name, "_busy_after_rdy"}, busy, 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [3:0] base;
    int         sa;
    logic [3:0] sav;
    int         sb;
    logic [3:0] sbv;
    int         nsamp;
    int         hold;
    int         exp_idx;
    int         exp_score;
  } vec_t;

  vec_t vecs[NVEC];

  initial begin
    logic [MODN*4-1:0] bus;
    int seen;

    vecs[0] = '{4'd5,  7, 4'd1,  -1, 4'd0,   4, 20,  7,    4};
    vecs[1] = '{4'd9,  3, 4'd0,  12, 4'd0,  10,  0,  3,    0};
    vecs[2] = '{4'd15, -1, 4'd0, -1, 4'd0, 300,  2,  0, 4095};
    vecs[3] = '{4'd2,  29, 4'd1, -1, 4'd0,   7,  1, 29,    7};
    vecs[4] = '{4'd3,  -1, 4'd0, -1, 4'd0,   5,  0,  0,   15};
    vecs[5] = '{4'd8,  20, 4'd4, 21, 4'd4,   3,  3, 20,   12};

    // reset state
    #12;
    check("reset_vld", match_vld, 0);
    check("reset_idx", match_idx, 0);
    check("reset_score", match_score, 0);
    check("reset_busy", busy, 0);
    check("reset_state", state_dbg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // frame_end / diff_vld in IDLE are ignored
    diff_vld = 1'b1;
    frame_end = 1'b1;
    diff_bus = '1;
    tick();
    tick();
    diff_vld = 1'b0;
    frame_end = 1'b0;
    check("idle_ignore_busy", busy, 0);

    for (int v = 0; v < NVEC; v++) begin
      bus = make_bus(vecs[v].base, vecs[v].sa, vecs[v].sav, vecs[v].sb, vecs[v].sbv);
      exp_q.push_back({vecs[v].exp_idx[IDXW-1:0], vecs[v].exp_score[ACCW-1:0]});
      send_frame(bus, vecs[v].nsamp);
      check($sformatf("vec%0d_busy_scan", v), busy, 1);
      wait_result($sformatf("vec%0d", v));
      finish_result($sformatf("vec%0d", v), vecs[v].hold);
    end

    // restart mid-frame; the restart pulse coincides with frame_end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    send_samples(make_bus(4'd7, -1, 4'd0, -1, 4'd0), 3, 1'b0);
    frame_start = 1'b1;
    frame_end = 1'b1;
    tick();
    frame_start = 1'b0;
    frame_end = 1'b0;
    check("restart_stays_accum", state_dbg, 1);
    exp_q.push_back({5'd5, 12'd0});
    send_samples(make_bus(4'd2, 5, 4'd0, -1, 4'd0), 2, 1'b1);
    wait_result("restart");
    finish_result("restart", 0);

    // rebuild a nonzero result so reset clearing is visible
    exp_q.push_back({5'd7, 12'd4});
    send_frame(make_bus(4'd5, 7, 4'd1, -1, 4'd0), 4);
    wait_result("pre_reset");
    finish_result("pre_reset", 0);

    // reset asserted at scan index 10
    send_frame(make_bus(4'd5, 7, 4'd1, -1, 4'd0), 4);
    for (int i = 0; i < 10; i++) tick();
    check("midscan_state", state_dbg, 2);
    rst_n = 1'b0;
    #1;
    check("midscan_rst_vld", match_vld, 0);
    check("midscan_rst_idx", match_idx, 0);
    check("midscan_rst_score", match_score, 0);
    check("midscan_rst_busy", busy, 0);
`ifdef FEATURE_MATCH_THRESH_EN
    check("midscan_rst_no_match", no_match, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (match_vld || busy) seen++;
    end
    check("midscan_no_result", seen, 0);

`ifdef FEATURE_MATCH_THRESH_EN
    match_thresh = 12'd3;
    exp_nm = 1'b1;
    exp_q.push_back({5'd31, 12'd4});
    send_frame(make_bus(4'd5, 7, 4'd1, -1, 4'd0), 4);
    wait_result("thresh");
    finish_result("thresh", 0);
    match_thresh = '1;
    exp_nm = 1'b0;
`endif

    check("exp_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
